// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and legality check for the load/store unit
// Sub-word support is enabled by defining LSU_SUBWORD_EN.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } lsu_state_t;

   // Load-side legality only; stores with the unsigned codes are rejected by the caller.
   function automatic logic is_illegal(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic r_bad;
      r_bad = 1'b1;
`ifdef LSU_SUBWORD_EN
      case (funct3)
         F3_B, F3_BU: r_bad = 1'b0;
         F3_H, F3_HU: r_bad = addr_lo[0];
         F3_W:        r_bad = (addr_lo != 2'b00);
         default:     r_bad = 1'b1;
      endcase
`else
      r_bad = (funct3 != F3_W) || (addr_lo != 2'b00);
`endif
      return r_bad;
   endfunction

endpackage

// File: rtl/lsu_lanes.sv
// rtl/lsu_lanes.sv - byte/halfword lane extraction with extension, and sub-word store merge
// Instantiated only when LSU_SUBWORD_EN is defined.
module lsu_lanes
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_load_data = i_word;
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_load_data = {24'h000000, w_byte};
         F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_load_data = {16'h0000, w_half};
         default: o_load_data = i_word;
      endcase
   end

   always_comb begin
      o_merged = i_word;
      case (i_funct3)
         F3_B: o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
         F3_H: begin
            if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
            else              o_merged[15:0]  = i_wdata[15:0];
         end
         default: o_merged = i_wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit between memory stage and word-wide data RAM
// Define LSU_SUBWORD_EN for byte/halfword accesses (read-modify-write stores); otherwise LW/SW only.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter  int profundidad = 1024,
   localparam int ADDR_W      = $clog2(profundidad)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              misaligned,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_MemWrite,
   output logic              mem_MemRead,
   input  logic [31:0]       mem_read_data
);

   lsu_state_t        r_state;
   logic              r_resp_valid;
   logic [31:0]       r_resp_rdata;
   logic              r_misaligned;

   logic              w_accept;
   logic              w_illegal;
   logic              w_ok;
   logic              w_load;
   logic              w_sw;
   logic              w_rmw;
   logic              w_in_write;
   logic [ADDR_W-1:0] w_index;
   logic [31:0]       w_load_data;
   logic              w_unused;

   // Upper address bits are deliberately dropped so accesses wrap around the RAM.
   assign w_index  = req_addr[ADDR_W+1:2];
   assign w_unused = ^req_addr[31:ADDR_W+2];

   assign req_ready  = (r_state == IDLE) && !reset;
   assign w_accept   = req_valid && req_ready;
   assign w_illegal  = is_illegal(req_funct3, req_addr[1:0]) || (req_write && req_funct3[2]);
   assign w_ok       = w_accept && !w_illegal;
   assign w_load     = w_ok && !req_write;
   assign w_sw       = w_ok && req_write && (req_funct3 == F3_W);

`ifdef LSU_SUBWORD_EN
   logic [ADDR_W-1:0] r_wr_index;
   logic [31:0]       r_wr_word;
   logic [31:0]       w_merged;

   assign w_rmw      = w_ok && req_write && (req_funct3 != F3_W);
   assign w_in_write = (r_state == WRITE) && !reset;

   lsu_lanes u_lanes (
      .i_word      (mem_read_data),
      .i_wdata     (req_wdata),
      .i_addr_lo   (req_addr[1:0]),
      .i_funct3    (req_funct3),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );
`else
   assign w_rmw       = 1'b0;
   assign w_in_write  = 1'b0;
   assign w_load_data = mem_read_data;
`endif

   always_comb begin
      mem_MemRead    = w_load || w_rmw;
      mem_MemWrite   = w_sw || w_in_write;
      mem_address    = '0;
      mem_write_data = 32'h0;
`ifdef LSU_SUBWORD_EN
      if (w_in_write) begin
         mem_address    = r_wr_index;
         mem_write_data = r_wr_word;
      end else
`endif
      if (w_ok) begin
         mem_address = w_index;
         if (w_sw) mem_write_data = req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_misaligned <= 1'b0;
`ifdef LSU_SUBWORD_EN
         r_wr_index   <= '0;
         r_wr_word    <= 32'h0;
`endif
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_misaligned <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_illegal) begin
                     r_resp_valid <= 1'b1;
                     r_misaligned <= 1'b1;
                  end else if (!req_write) begin
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= w_load_data;
                  end else if (req_funct3 == F3_W) begin
                     r_resp_valid <= 1'b1;
                  end
`ifdef LSU_SUBWORD_EN
                  else begin
                     r_wr_index <= w_index;
                     r_wr_word  <= w_merged;
                     r_state    <= WRITE;
                  end
`endif
               end
            end
`ifdef LSU_SUBWORD_EN
            // The RAM commits the merged word on this edge; complete one cycle later.
            WRITE: begin
               r_state      <= IDLE;
               r_resp_valid <= 1'b1;
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign misaligned = r_misaligned;

endmodule
